// File: rtl/shifter_unit_if.sv
// Handshake and shared adder/comparator bus between the parent datapath and shifter_unit.
// The master side is the parent that issues requests and owns the shared Adder/Comparator.
interface shifter_unit_if #(parameter int N = 4);
  logic         i_start;
  logic         o_finished;
  logic         i_direction;
  logic         i_rotate;
  logic [N-1:0] i_iterations;
  logic [N-1:0] i_value;
  logic [N-1:0] o_result;
  logic [N-1:0] o_adder_augend;
  logic [N-1:0] o_adder_addend;
  logic [N-1:0] i_adder_sum;
  logic [N-1:0] o_comparator_left;
  logic [N-1:0] o_comparator_right;
  logic         i_comparator_equal;

  modport master (
    output i_start, i_direction, i_rotate, i_iterations, i_value,
    output i_adder_sum, i_comparator_equal,
    input  o_finished, o_result, o_adder_augend, o_adder_addend,
    input  o_comparator_left, o_comparator_right
  );

  modport slave (
    input  i_start, i_direction, i_rotate, i_iterations, i_value,
    input  i_adder_sum, i_comparator_equal,
    output o_finished, o_result, o_adder_augend, o_adder_addend,
    output o_comparator_left, o_comparator_right
  );
endinterface

// File: rtl/shifter_unit.sv
// Multi-cycle shift/rotate engine: one bit position per clock, counting and
// termination delegated to the parent's shared adder and equality comparator.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for i_start; operands latched on the start edge
// S_SHIFT | one step per edge until counter equals latched iterations
// S_DONE  | o_finished high, result held until i_start drops
module shifter_unit #(
  parameter int N = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  shifter_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] value_q, value_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] iters_q, iters_d;
  logic         dir_q, dir_d;
  logic         rot_q, rot_d;
  logic [N-1:0] step_val;

  // Vacated bit is zero for a logical shift, the bit shifted out for a rotate.
  always_comb begin
    step_val = value_q;
    if (!dir_q) begin
      step_val = {value_q[N-2:0], rot_q ? value_q[N-1] : 1'b0};
    end else begin
      step_val = {rot_q ? value_q[0] : 1'b0, value_q[N-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    count_d = count_q;
    iters_d = iters_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          value_d = bus.i_value;
          iters_d = bus.i_iterations;
          dir_d   = bus.i_direction;
          rot_d   = bus.i_rotate;
          count_d = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Termination is tested before stepping so zero iterations leave the operand untouched.
        if (bus.i_comparator_equal) begin
          state_d = S_DONE;
        end else begin
          value_d = step_val;
          count_d = bus.i_adder_sum;
        end
      end
      S_DONE: begin
        if (!bus.i_start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      value_q <= '0;
      count_q <= '0;
      iters_q <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      count_q <= count_d;
      iters_q <= iters_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  assign bus.o_finished         = (state_q == S_DONE);
  assign bus.o_result           = value_q;
  assign bus.o_adder_augend     = count_q;
  assign bus.o_adder_addend     = {{(N-1){1'b0}}, 1'b1};
  assign bus.o_comparator_left  = count_q;
  assign bus.o_comparator_right = iters_q;

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit: closed-form shift/rotate model checked
// every cycle, plus directed literal cases and randomized operations.
module tb_shifter_unit;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  shifter_unit_if #(.N(N)) bus ();

  shifter_unit #(.N(N)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Parent-side shared adder and comparator.
  assign bus.i_adder_sum        = bus.o_adder_augend + bus.o_adder_addend;
  assign bus.i_comparator_equal = (bus.o_comparator_left == bus.o_comparator_right);

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Result of shifting/rotating v by k single-bit steps, in closed form.
  function automatic logic [N-1:0] model_shift(input logic [N-1:0] v, input int k,
                                               input logic dir, input logic rot);
    logic [2*N-1:0] w;
    int r;
    w = {{N{1'b0}}, v};
    if (rot) begin
      r = k % N;
      if (r == 0) return v;
      if (!dir) w = (w << r) | (w >> (N - r));
      else      w = (w >> r) | (w << (N - r));
      return w[N-1:0];
    end
    if (k >= N) return '0;
    if (!dir) w = w << k;
    else      w = w >> k;
    return w[N-1:0];
  endfunction

  // Behavioural model: 0 idle, 1 busy with m_c steps done, 2 done.
  int           m_ph = 0;
  int           m_c  = 0;
  int           m_k  = 0;
  logic [N-1:0] m_v  = '0;
  logic         m_d  = 1'b0;
  logic         m_r  = 1'b0;
  logic [N-1:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_c <= 0; m_k <= 0; m_v <= '0; m_d <= 1'b0; m_r <= 1'b0; m_res <= '0;
    end else begin
      case (m_ph)
        0: if (bus.i_start) begin
             m_v <= bus.i_value; m_k <= int'(bus.i_iterations);
             m_d <= bus.i_direction; m_r <= bus.i_rotate;
             m_c <= 0; m_res <= bus.i_value; m_ph <= 1;
           end
        1: if (m_c == m_k) m_ph <= 2;
           else begin
             m_c   <= m_c + 1;
             m_res <= model_shift(m_v, m_c + 1, m_d, m_r);
           end
        default: if (!bus.i_start) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("result",   int'(bus.o_result),           int'(m_res));
    check("finished", int'(bus.o_finished),         (m_ph == 2) ? 1 : 0);
    check("augend",   int'(bus.o_adder_augend),     m_c);
    check("addend",   int'(bus.o_adder_addend),     1);
    check("cmp_left", int'(bus.o_comparator_left),  m_c);
    check("cmp_right",int'(bus.o_comparator_right), m_k);
  end

  task automatic run_op(input logic [N-1:0] v, input int k, input logic d, input logic r,
                        input int hold_cycles, output int lat, output logic [N-1:0] res);
    @(posedge clk); #2;
    bus.i_value = v; bus.i_iterations = N'(k); bus.i_direction = d; bus.i_rotate = r;
    bus.i_start = 1'b1;
    @(posedge clk); #2;
    bus.i_start = (hold_cycles > 0) ? 1'b1 : 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (bus.o_finished) break;
      bus.i_value = N'($urandom); bus.i_iterations = N'($urandom);
      bus.i_direction = 1'($urandom); bus.i_rotate = 1'($urandom);
    end
    res = bus.o_result;
    if (hold_cycles > 0) begin
      repeat (hold_cycles) @(posedge clk);
      #1 check("hold_finished", int'(bus.o_finished), 1);
      #1 bus.i_start = 1'b0;
    end
  endtask

  task automatic directed(input string name, input logic [N-1:0] v, input int k,
                          input logic d, input logic r, input logic [N-1:0] exp_res);
    int lat;
    logic [N-1:0] res;
    check({name, "_model"}, int'(model_shift(v, k, d, r)), int'(exp_res));
    run_op(v, k, d, r, 0, lat, res);
    check({name, "_latency"}, lat, k + 1);
    check({name, "_res"}, int'(res), int'(exp_res));
  endtask

  initial begin
    int lat;
    logic [N-1:0] res;
    logic [N-1:0] rv;
    int rk;
    logic rd, rr;
    bus.i_start = 1'b0; bus.i_value = '0; bus.i_iterations = '0;
    bus.i_direction = 1'b0; bus.i_rotate = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_result", int'(bus.o_result), 0);
    check("rst_finished", int'(bus.o_finished), 0);
    check("rst_addend", int'(bus.o_adder_addend), 1);
    check("rst_right", int'(bus.o_comparator_right), 0);
    #2 rst_n = 1'b1;

    directed("l_log_1",  4'b1011, 1,  1'b0, 1'b0, 4'b0110);
    directed("r_rot_1",  4'b1011, 1,  1'b1, 1'b1, 4'b1101);
    directed("l_rot_2",  4'b1011, 2,  1'b0, 1'b1, 4'b1110);
    directed("zero_it",  4'b1011, 0,  1'b1, 1'b0, 4'b1011);
    check("zero_it_counter", int'(bus.o_adder_augend), 0);
    directed("r_log_5",  4'b1111, 5,  1'b1, 1'b0, 4'b0000);
    directed("l_rot_5",  4'b0001, 5,  1'b0, 1'b1, 4'b0010);
    directed("l_log_15", 4'b1011, 15, 1'b0, 1'b0, 4'b0000);
    directed("r_rot_15", 4'b1011, 15, 1'b1, 1'b1, 4'b0111);

    // Start held high through DONE: no restart, then released back to IDLE.
    run_op(4'b1011, 2, 1'b1, 1'b0, 4, lat, res);
    check("hold_latency", lat, 3);
    check("hold_res", int'(res), 4'b0010);
    @(posedge clk); #1;
    check("hold_released", int'(bus.o_finished), 0);
    directed("after_hold", 4'b0110, 1, 1'b0, 1'b1, 4'b1100);

    // Reset asserted mid-shift aborts at once.
    @(posedge clk); #2;
    bus.i_value = 4'b1011; bus.i_iterations = 4'd3; bus.i_direction = 1'b0; bus.i_rotate = 1'b0;
    bus.i_start = 1'b1;
    @(posedge clk); #2 bus.i_start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_value", int'(bus.o_result), 4'b1100);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", int'(bus.o_result), 0);
    check("abort_finished", int'(bus.o_finished), 0);
    check("abort_counter", int'(bus.o_adder_augend), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    directed("after_rst", 4'b1011, 3, 1'b0, 1'b0, 4'b1000);

    for (int i = 0; i < 60; i++) begin
      rv = N'($urandom); rk = int'($urandom_range(0, 15));
      rd = 1'($urandom); rr = 1'($urandom);
      run_op(rv, rk, rd, rr, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, lat, res);
      check("rand_latency", lat, rk + 1);
      check("rand_res", int'(res), int'(model_shift(rv, rk, rd, rr)));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
